// File: rtl/dac_axis_stream_buffer.sv
// dac_axis_stream_buffer: elastic AXIS FIFO that primes, absorbs RFDC backpressure and fills underruns with zero words
module dac_axis_stream_buffer #(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear_counters,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [ADDR_WIDTH:0]        fill_level,
  output logic [31:0]                overflow_count,
  output logic [31:0]                underrun_count,
  output logic [1:0]                 state_out
);
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, UNDERRUN} state_t;
  localparam logic [ADDR_WIDTH:0] full_lvl = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] prime_lvl = (ADDR_WIDTH+1)'(PRIME_LEVEL);
  state_t state;
  logic [AXIS_DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic full, empty, push, pop, drop, under_beat, flush, primed;
  always_comb begin
    full = fill_level == full_lvl;
    empty = fill_level == '0;
    primed = fill_level >= prime_lvl;
    flush = !enable || state == IDLE;
    m_axis_tvalid = state == STREAM || state == UNDERRUN;
    pop = m_axis_tvalid && m_axis_tready && !empty && state == STREAM;
    s_axis_tready = state != IDLE && (!full || pop);
    push = s_axis_tvalid && s_axis_tready;
    drop = state != IDLE && s_axis_tvalid && !s_axis_tready;
    under_beat = m_axis_tready && ((state == STREAM && empty) || state == UNDERRUN);
    m_axis_tdata = (state == STREAM && !empty) ? mem[rd_ptr] : '0;
    state_out = state;
  end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= s_axis_tdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill_level <= '0;
      overflow_count <= '0;
      underrun_count <= '0;
    end else begin
      rd_ptr <= flush ? '0 : rd_ptr + ADDR_WIDTH'(pop);
      wr_ptr <= flush ? '0 : wr_ptr + ADDR_WIDTH'(push);
      fill_level <= flush ? '0 : fill_level + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
      overflow_count <= clear_counters ? '0 : overflow_count + 32'(drop && ~&overflow_count);
      underrun_count <= clear_counters ? '0 : underrun_count + 32'(under_beat && ~&underrun_count);
      state <= !enable ? IDLE :
               state == IDLE ? PRIME :
               state == STREAM ? ((empty && m_axis_tready) ? UNDERRUN : STREAM) :
               primed ? STREAM : state;
    end
  end
endmodule

// File: tb/tb_dac_axis_stream_buffer.sv
// tb_dac_axis_stream_buffer: directed checks of priming, backpressure, underrun, flush and reset
module tb_dac_axis_stream_buffer;
  logic clk = 0;
  logic rst = 1, en = 0, clr = 0, s_valid = 0, m_ready = 0;
  logic [255:0] s_data = '0;
  logic s_ready, m_valid;
  logic [255:0] m_data;
  logic [4:0] fill;
  logic [31:0] ovf, und;
  logic [1:0] st;
  logic [255:0] beats[$];
  int n_chk = 0, n_pass = 0;
  int i_fill = 0, i_valid = 0;

  dac_axis_stream_buffer dut (
    .clk(clk), .reset(rst), .enable(en), .clear_counters(clr),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .fill_level(fill), .overflow_count(ovf), .underrun_count(und), .state_out(st)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && m_valid && m_ready) beats.push_back(m_data);

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      s_valid = 1;
      s_data = 256'(base + k);
      tick;
    end
    s_valid = 0;
  endtask

  task automatic check_beats(input string tag, input int base, input int n);
    check({tag, "_count"}, 256'(beats.size()), 256'(n));
    for (int k = 0; k < n; k++) check(tag, k < beats.size() ? beats[k] : 256'hx, 256'(base + k));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 256'(st), 0);
    check({tag, "_fill"}, 256'(fill), 0);
    check({tag, "_ovf"}, 256'(ovf), 0);
    check({tag, "_und"}, 256'(und), 0);
    check({tag, "_mvalid"}, 256'(m_valid), 0);
    check({tag, "_mdata"}, m_data, 0);
    check({tag, "_sready"}, 256'(s_ready), 0);
  endtask

  initial begin
    tick;
    check_reset_outputs("rst");
    rst = 0; en = 1; m_ready = 1;
    tick;
    check("prime_state", 256'(st), 1);
    beats.delete();
    for (int k = 1; k <= 6; k++) begin
      s_valid = 1;
      s_data = 256'(k);
      tick;
      if (fill == 5'd4 && i_fill == 0) i_fill = k;
      if (m_valid && i_valid == 0) i_valid = k;
    end
    s_valid = 0;
    check("fill_hits_4", 256'(i_fill), 4);
    check("tvalid_rise", 256'(i_valid), 5);
    repeat (5) tick;
    check("drained_fill", 256'(fill), 0);
    check("drained_state", 256'(st), 2);
    repeat (10) tick;
    check("und_state", 256'(st), 3);
    check("und_count", 256'(und), 10);
    check("und_mvalid", 256'(m_valid), 1);
    check("und_mdata", m_data, 0);
    check("stream_beats_count", 256'(beats.size()), 16);
    for (int k = 0; k < 16; k++)
      check("stream_beat", k < beats.size() ? beats[k] : 256'hx, 256'(k < 6 ? k + 1 : 0));
    push_words(101, 4);
    check("und_refill_state", 256'(st), 3);
    tick;
    check("resume_state", 256'(st), 2);
    check("resume_und", 256'(und), 15);
    beats.delete();
    repeat (4) tick;
    m_ready = 0;
    check_beats("resume_beats", 101, 4);

    rst = 1;
    tick;
    rst = 0;
    check("rst2_state", 256'(st), 0);
    tick;
    beats.delete();
    push_words(1, 20);
    check("ovf_fill", 256'(fill), 16);
    check("ovf_count", 256'(ovf), 4);
    check("ovf_sready", 256'(s_ready), 0);
    check("ovf_head", m_data, 1);
    m_ready = 1;
    repeat (16) tick;
    m_ready = 0;
    check_beats("ovf_beats", 1, 16);

    push_words(201, 16);
    check("full_fill", 256'(fill), 16);
    beats.delete();
    m_ready = 1;
    push_words(217, 8);
    check("pp_fill", 256'(fill), 16);
    check("pp_ovf", 256'(ovf), 4);
    repeat (16) tick;
    m_ready = 0;
    check("pp_und", 256'(und), 0);
    check_beats("pp_beats", 201, 24);

    m_ready = 1;
    repeat (3) tick;
    m_ready = 0;
    push_words(301, 7);
    check("pre_drop_fill", 256'(fill), 7);
    check("pre_drop_state", 256'(st), 2);
    check("pre_drop_und", 256'(und), 3);
    en = 0;
    tick;
    en = 1;
    check("drop_state", 256'(st), 0);
    check("drop_fill", 256'(fill), 0);
    check("drop_mvalid", 256'(m_valid), 0);
    check("drop_ovf", 256'(ovf), 4);
    check("drop_und", 256'(und), 3);
    tick;
    check("reen_state", 256'(st), 1);
    push_words(401, 4);
    tick;
    m_ready = 1;
    repeat (4) tick;
    check("preclr_und", 256'(und), 3);
    clr = 1;
    tick;
    clr = 0;
    check("clr_und", 256'(und), 0);
    check("clr_ovf", 256'(ovf), 0);
    check("clr_state", 256'(st), 3);
    tick;
    check("postclr_und", 256'(und), 1);

    push_words(501, 5);
    check("prerst_state", 256'(st), 2);
    rst = 1;
    tick;
    rst = 0;
    check_reset_outputs("midrst");
    tick;
    check("midrst_prime", 256'(st), 1);
    check("midrst_fill", 256'(fill), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dac_axis_stream_buffer.md
Name: dac_axis_stream_buffer

Overview:
- Elastic 256-bit AXIS buffer between the DAC controller's sample-stream output (DDS or direct mode) and the RFDC DAC tile input.
- The upstream DDS path emits one word per cycle and ignores backpressure. The block absorbs tready gaps, primes before streaming, and emits zero words on underrun so the RFDC never sees a tvalid hole mid-stream.
- Drops and underruns are counted and exposed to software for diagnosis.

Parameters:
- AXIS_DATA_WIDTH, 256, width of one sample word (16 x 16-bit samples).
- DEPTH, 16, FIFO depth in words; must be a power of 2, at least 4.
- ADDR_WIDTH, 4, log2(DEPTH).
- PRIME_LEVEL, 4, fill level required before streaming starts or resumes; must satisfy 1 <= PRIME_LEVEL <= DEPTH.

Ports:
- clk  in  1  single clock for the whole block (RFDC AXIS clock domain).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run, 0 = flush and idle.
- clear_counters  in  1  single-cycle pulse; zeroes both error counters.
- s_axis_tdata  in  AXIS_DATA_WIDTH  upstream sample word.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  advisory ready; upstream may ignore it.
- m_axis_tdata  out  AXIS_DATA_WIDTH  word to RFDC.
- m_axis_tvalid  out  1  valid to RFDC.
- m_axis_tready  in  1  RFDC ready.
- fill_level  out  ADDR_WIDTH+1  words currently stored.
- overflow_count  out  32  upstream words dropped.
- underrun_count  out  32  zero words emitted on underrun.
- state_out  out  2  current FSM state (IDLE=0, PRIME=1, STREAM=2, UNDERRUN=3).

Behaviour:
- Reset values:
  - FSM = IDLE.
  - Read pointer, write pointer, fill_level, overflow_count and underrun_count all = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0.
  - s_axis_tready = 0.
- Storage:
  - DEPTH x AXIS_DATA_WIDTH array, ADDR_WIDTH-bit pointers that wrap modulo DEPTH, separate (ADDR_WIDTH+1)-bit occupancy counter.
  - full = (fill_level == DEPTH); empty = (fill_level == 0).
- Write path:
  - push = s_axis_tvalid && s_axis_tready.
  - s_axis_tready = (state != IDLE) && (!full || pop).
  - A word pushed in cycle N is readable at the FIFO head in cycle N+1. There is no same-cycle fall-through into an empty FIFO.
- Overflow:
  - Condition: state != IDLE, s_axis_tvalid = 1 and s_axis_tready = 0. The word is dropped and overflow_count increments by 1.
  - s_axis_tvalid in IDLE is ignored and not counted.
- Read path:
  - pop = m_axis_tvalid && m_axis_tready && !empty && state == STREAM.
  - m_axis_tdata = mem[rd_ptr] when state == STREAM and !empty; otherwise 0.
- Occupancy update: fill_level_next = fill_level + push - pop. Simultaneous push and pop leaves the level unchanged, including when full.
- FSM (evaluated each clk edge; enable == 0 has priority in every state):
  - IDLE:
    - m_axis_tvalid = 0.
    - Pointers and fill_level are forced to 0 (flush).
    - Goes to PRIME when enable = 1.
  - PRIME:
    - m_axis_tvalid = 0; writes accepted.
    - Goes to STREAM when fill_level >= PRIME_LEVEL, evaluated on the registered level.
  - STREAM:
    - m_axis_tvalid = 1.
    - If empty and m_axis_tready = 1: a zero word is delivered, underrun_count increments, next state = UNDERRUN.
    - If empty and m_axis_tready = 0: stay in STREAM, no count.
  - UNDERRUN:
    - m_axis_tvalid = 1, m_axis_tdata = 0.
    - Each accepted beat (m_axis_tready = 1) increments underrun_count.
    - Goes to STREAM when fill_level >= PRIME_LEVEL.
  - Any state with enable = 0: next state = IDLE and flush takes effect in the same edge. Counters are held (not cleared).
- Counters:
  - 32-bit, saturate at 0xFFFFFFFF (no wrap).
  - clear_counters zeroes both on the next edge. If clear_counters coincides with an increment event, the clear wins and the result is 0.
- Reset mid-operation: a synchronous reset overrides enable, clear_counters and all handshakes. All state returns to the reset values on the same edge; stored data is discarded.
- fill_level and state_out are registered and reflect the post-edge values.

Test Plan:
- Prime and stream:
  - Stimulus: reset, enable = 1, push words 1..6 back-to-back, m_axis_tready = 1.
  - Required: m_axis_tvalid first rises the cycle after fill_level reaches 4. Output sequence is 1, 2, 3, 4, 5, 6 with no gaps while upstream keeps pace.
- Backpressure and overflow:
  - Stimulus: DEPTH = 16, m_axis_tready = 0, push 20 consecutive words.
  - Required: fill_level saturates at 16 and overflow_count = 4. After releasing tready, the output is words 1..16 in order.
- Underrun:
  - Stimulus: reach STREAM, stop pushing, hold m_axis_tready = 1 for 10 cycles after the FIFO drains.
  - Required: state = UNDERRUN, output words = 0 with tvalid = 1, underrun_count = 10.
  - Follow-up: push 4 words; state returns to STREAM and those words appear in order.
- Simultaneous push/pop at full:
  - Stimulus: fill to 16, then push and pop in the same cycle for 8 cycles.
  - Required: fill_level stays 16, overflow_count unchanged, data order preserved.
- Enable drop and counter control:
  - Stimulus: in STREAM with 7 stored words, drop enable for 1 cycle.
  - Required: next cycle state = IDLE, fill_level = 0, m_axis_tvalid = 0, counters retained.
  - Follow-up: pulse clear_counters in the same cycle as an underrun beat; both counters read 0 afterward.
- Mid-stream reset:
  - Stimulus: assert reset for 1 cycle while streaming.
  - Required: next cycle all outputs at reset values. With enable still high, the following cycle state = PRIME.
